// File: rtl/uart_word_deframer_pkg.sv
// Shared definitions for the UART word deframer.
//   state_t            : frame-parser state encoding
//   SYNC_BYTE_DEFAULT  : default frame header value
//   timeout_width()    : bit width needed to count up to a timeout limit
package uart_word_deframer_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    PAYLOAD = 2'b01,
    CHECK   = 2'b10
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int timeout_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/uart_word_deframer_if.sv
// Byte-in / word-out bus of the UART word deframer.
//   rx_data, rx_done      : received byte and its one-cycle strobe
//   word_data, word_valid : assembled word and its "unread" flag
//   word_ready            : consumer accepts when word_valid && word_ready
// master = the deframer, slave = the surrounding UART RX plus word consumer.
interface uart_word_deframer_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (
    input  rx_data, rx_done, word_ready,
    output word_data, word_valid
  );

  modport slave (
    output rx_data, rx_done, word_ready,
    input  word_data, word_valid
  );
endinterface

// File: rtl/uart_word_deframer_word_out_reg.sv
// One-deep valid/ready holding register with overrun detection.
//   sysclk, rst_n : clock, asynchronous active-low reset
//   commit        : load commit_data this cycle (a good frame just ended)
//   commit_data   : word to load
//   ready         : consumer accept
//   data, valid   : held word and its unread flag
//   overrun       : sticky, a commit arrived while an unread word was held
module uart_word_deframer_word_out_reg (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        commit,
  input  logic [31:0] commit_data,
  input  logic        ready,
  output logic [31:0] data,
  output logic        valid,
  output logic        overrun
);

  logic accept;
  assign accept = valid && ready;

  // NOTE: state updates use non-blocking assignments so every register in
  // the block samples the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A word leaving this cycle frees the slot for a commit in the same
      // cycle, so the register never stalls a back-to-back stream.
      if (commit && (!valid || accept)) begin
        data  <= commit_data;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      // The held word wins; the incoming one is dropped and flagged.
      if (commit && valid && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_word_deframer.sv
// Rebuilds multi-byte words from a UART RX byte stream.
// Frame: SYNC_BYTE, NBYTES payload bytes LSB first, XOR checksum of payload.
//   sysclk, rst_n : clock, asynchronous active-low reset
//   bus (master)  : rx_data/rx_done in, word_data/word_valid/word_ready out
//   crc_err       : one-cycle pulse on checksum mismatch
//   timeout_err   : one-cycle pulse when a frame stalls too long between bytes
//   overrun       : sticky, a good frame completed while a word was unread
//   busy          : parser is inside a frame
module uart_word_deframer
  import uart_word_deframer_pkg::*;
#(
  parameter int         CLK_FREQ    = 12_000_000,
  parameter int         NBYTES      = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 12_000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  uart_word_deframer_if.master bus,
  output logic                 crc_err,
  output logic                 timeout_err,
  output logic                 overrun,
  output logic                 busy
);

  // The inter-byte gap is never allowed to exceed one second of sysclk,
  // which also bounds the timer width for any parameter combination.
  localparam int TMO_LIMIT = (TIMEOUT_CYC < CLK_FREQ) ? TIMEOUT_CYC : CLK_FREQ;
  localparam int TMR_W     = timeout_width(TMO_LIMIT);
  localparam int IDX_W     = 2;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       acc;
  logic [TMR_W-1:0] timer;
  logic [3:0][7:0]  slots;     // slots[0] lands in word bits 7:0
  logic             commit;
  logic             timer_done;

  // Combinational so the word register loads on the checksum strobe edge,
  // giving word_valid one cycle after the checksum byte.
  assign commit     = (state == CHECK) && bus.rx_done && (bus.rx_data == acc);
  assign timer_done = (timer == TMR_W'(TMO_LIMIT));
  assign busy       = (state != HUNT);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      acc         <= '0;
      timer       <= '0;
      // NOTE: the byte slots are reset too; slots above NBYTES are never
      // written afterwards, so this is what makes unused word bits read 0.
      slots       <= '0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        HUNT: begin
          timer <= '0;
          if (bus.rx_done && bus.rx_data == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= '0;
            acc   <= '0;
          end
        end
        PAYLOAD: begin
          // A byte arriving on the terminal count is still taken.
          if (bus.rx_done) begin
            slots[idx] <= bus.rx_data;
            acc        <= acc ^ bus.rx_data;
            idx        <= idx + 1'b1;
            timer      <= '0;
            if (idx == IDX_W'(NBYTES - 1)) state <= CHECK;
          end else if (timer_done) begin
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (bus.rx_done) begin
            crc_err <= (bus.rx_data != acc);
            timer   <= '0;
            state   <= HUNT;
          end else if (timer_done) begin
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  uart_word_deframer_word_out_reg u_word_out_reg (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .commit      (commit),
    .commit_data (slots),
    .ready       (bus.word_ready),
    .data        (bus.word_data),
    .valid       (bus.word_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_uart_word_deframer.sv
// Scoreboard bench for uart_word_deframer: a frame-level byte parser model
// pushes expected words; a negedge monitor pops and compares.
module tb_uart_word_deframer;

  localparam int         NB   = 4;
  localparam int         TMO  = 200;
  localparam logic [7:0] SYNC = 8'hA5;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic crc_err, timeout_err, overrun, busy;

  uart_word_deframer_if bus ();

  uart_word_deframer #(.NBYTES(NB), .TIMEOUT_CYC(TMO)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .bus         (bus),
    .crc_err     (crc_err),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid   = 1'b0;
  bit          m_overrun = 1'b0;
  bit          in_frame  = 1'b0;
  bit          abort_req = 1'b0;
  bit          abort_seen = 1'b0;
  logic [7:0]  frame[$];
  logic [31:0] exp_q[$];
  int          crc_exp = 0;
  bit          good;
  logic [7:0]  x;
  logic [31:0] w;

  initial forever begin
    @(posedge sysclk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 0; m_overrun = 0; in_frame = 0;
      frame.delete(); exp_q.delete(); abort_seen = abort_req;
    end else begin
      good = 0;
      if (abort_req != abort_seen) begin
        abort_seen = abort_req; in_frame = 0; frame.delete();
      end
      if (bus.rx_done) begin
        if (!in_frame) begin
          if (bus.rx_data == SYNC) begin in_frame = 1; frame.delete(); end
        end else if (frame.size() < NB) begin
          frame.push_back(bus.rx_data);
        end else begin
          x = 0; w = 0;
          foreach (frame[i]) begin
            x ^= frame[i];
            w |= 32'(frame[i]) << (8 * i);
          end
          if (x == bus.rx_data) good = 1; else crc_exp++;
          in_frame = 0;
        end
      end
      if (good) begin
        if (!m_valid || bus.word_ready) begin m_valid = 1; exp_q.push_back(w); end
        else m_overrun = 1;
      end else if (m_valid && bus.word_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int          crc_seen = 0, to_seen = 0, words_seen = 0;
  logic [31:0] last_word = '0;

  initial forever begin
    @(negedge sysclk);
    if (rst_n) begin
      check("word_valid", {31'b0, bus.word_valid}, {31'b0, m_valid});
      check("overrun", {31'b0, overrun}, {31'b0, m_overrun});
      if (bus.word_valid && exp_q.size() > 0) begin
        check("word_data", bus.word_data, exp_q[0]);
        if (bus.word_ready) begin
          last_word = exp_q.pop_front();
          words_seen++;
        end
      end
      if (crc_err) crc_seen++;
      if (timeout_err) to_seen++;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 1'b0;
  bit ready_ctl  = 1'b0;

  task automatic tick();
    @(posedge sysclk); #1;
    bus.word_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ready(input bit v);
    ready_ctl = v; bus.word_ready = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data = b; bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    idle(gap);
  endtask

  function automatic logic [7:0] xsum(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
  endfunction

  task automatic send_word(input logic [31:0] v, input logic [7:0] cs, input int gap);
    send_byte(SYNC, gap);
    for (int i = 0; i < NB; i++) send_byte(v[8*i +: 8], gap);
    send_byte(cs, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_valid"}, {31'b0, bus.word_valid}, 32'd0);
    check({tag, "_word_data"}, bus.word_data, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    check({tag, "_crc_err"}, {31'b0, crc_err}, 32'd0);
    check({tag, "_timeout_err"}, {31'b0, timeout_err}, 32'd0);
  endtask

  int words_before, crc_before;

  initial begin
    bus.rx_data = '0; bus.rx_done = 1'b0; bus.word_ready = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    check_reset_outputs("reset");

    // Good frame, consumer always ready
    set_ready(1);
    send_word(32'h12345678, 8'h08, 1);
    idle(3);
    check("good_words", words_seen, 1);
    check("good_last", last_word, 32'h12345678);
    check("good_crc", crc_seen, 0);

    // Bad checksum then good frame
    send_word(32'h12345678, 8'h09, 0);
    idle(3);
    check("bad_crc", crc_seen, 1);
    check("bad_words", words_seen, 1);
    send_word(32'h00000001, 8'h01, 1);
    idle(3);
    check("after_bad_last", last_word, 32'h00000001);

    // Leading garbage
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_word(32'hDEADBEEF, 8'h22, 0);
    idle(3);
    check("garbage_words", words_seen, 3);
    check("garbage_last", last_word, 32'hDEADBEEF);

    // Inter-byte timeout
    send_byte(SYNC, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("tmo_busy_mid", {31'b0, busy}, 32'd1);
    idle(TMO + 10);
    check("tmo_pulses", to_seen, 1);
    check("tmo_busy_after", {31'b0, busy}, 32'd0);
    check("tmo_words", words_seen, 3);
    abort_req = ~abort_req;
    send_word(32'hCAFEF00D, xsum(32'hCAFEF00D), 1);
    idle(3);
    check("tmo_next_last", last_word, 32'hCAFEF00D);

    // Randomized frames with random back-pressure
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      logic [31:0] v;
      logic [7:0]  cs;
      int          gap;
      gap = $urandom_range(0, 3);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == SYNC) junk = 8'h00;
        send_byte(junk, gap);
      end
      v = $urandom();
      if ($urandom_range(0, 4) == 0) v[15:8] = SYNC;
      cs = xsum(v);
      if ($urandom_range(0, 6) == 0) cs = cs ^ 8'h5A;
      send_word(v, cs, gap);
    end
    rand_ready = 0;
    set_ready(1);
    idle(5);
    check("drain_queue", exp_q.size(), 0);

    // Reset in the middle of a frame
    send_byte(SYNC, 1);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    rst_n = 1'b1;
    words_before = words_seen;
    crc_before   = crc_seen;
    send_byte(8'h34, 1);
    send_byte(8'h12, 1);
    send_byte(8'h08, 1);
    idle(4);
    check("midrst_words", words_seen, words_before);
    check("midrst_crc", crc_seen, crc_before);
    check("midrst_busy", {31'b0, busy}, 32'd0);

    // Overrun with consumer stalled
    set_ready(0);
    send_word(32'h12345678, 8'h08, 1);
    send_word(32'h00000001, 8'h01, 0);
    idle(3);
    check("ovr_flag", {31'b0, overrun}, 32'd1);
    check("ovr_valid", {31'b0, bus.word_valid}, 32'd1);
    check("ovr_data", bus.word_data, 32'h12345678);
    set_ready(1);
    tick();
    check("ovr_valid_falls", {31'b0, bus.word_valid}, 32'd0);
    idle(2);

    check("crc_total", crc_seen, crc_exp);
    check("tmo_total", to_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
